// File: rtl/demo_pkg.sv
// Shared definitions for the demo scene sequencer and its helpers.
//   state_e     : scene FSM encoding (exposed on the debug port)
//   mode_t      : effect mode selects decoded from the scene index
//   FADE_MAX    : brightness level at full intensity
//   mode_decode : scene index -> {mode_a, mode_b, zoom_mode}
package demo_pkg;

  typedef enum logic [1:0] {
    FADE_IN  = 2'd0,
    RUN      = 2'd1,
    FADE_OUT = 2'd2
  } state_e;

  typedef struct packed {
    logic mode_a;
    logic mode_b;
    logic zoom_mode;
  } mode_t;

  localparam logic [1:0] FADE_MAX = 2'd3;

  function automatic mode_t mode_decode(input logic [1:0] scene);
    mode_t m;
    m.mode_a    = scene[1];
    m.mode_b    = scene[1] ^ scene[0];
    m.zoom_mode = scene[1] & scene[0];
    return m;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick generator: rising-edge detect on a level vsync plus a
// registered one-cycle pulse. The pulse appears the cycle after the clock
// edge that first samples vsync high.
//   clk     : pixel clock
//   rst_n   : asynchronous active-low reset
//   vsync_i : level vsync, active high, synchronous to clk
//   tick_o  : one-cycle pulse per vsync rising edge
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_i,
  output logic tick_o
);

  logic vsync_q;
  logic tick_q;
  logic edge_d;

  assign edge_d = vsync_i & ~vsync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      tick_q  <= edge_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/demo_scene_sequencer.sv
// Scene scheduler for the VGA effect datapath. Counts frames from vsync and
// walks NUM_SCENES scenes, each sequenced FADE_IN -> RUN -> FADE_OUT, driving
// the fade level and effect mode selects used by the pixel pipe.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   FADE_IN  | fade ramps 0->3, one level per FADE_STEP frames
//   RUN      | fade held at 3 for RUN_FRAMES frames (or until skip)
//   FADE_OUT | fade ramps 3->0, then one more step at 0 before next scene
//
// Ports:
//   clk, rst_n          : pixel clock, async active-low reset
//   vsync               : level vsync from the sync generator
//   pause               : freezes counters and state while high
//   skip                : one-cycle request for an early fade-out
//   scene_lock/scene_sel: at scene advance, load scene_sel instead of +1
//   frame_tick          : one-cycle pulse per frame (ignores pause)
//   frame               : frames since scene start, mod 128
//   scene               : current scene index
//   mode_a/mode_b/zoom_mode : effect mode selects decoded from scene
//   fade                : brightness level, 0=black .. 3=full
//   state_o             : FSM state, debug
module demo_scene_sequencer
  import demo_pkg::*;
#(
  parameter int FADE_STEP  = 4,
  parameter int RUN_FRAMES = 96,
  parameter int NUM_SCENES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       pause,
  input  logic       skip,
  input  logic       scene_lock,
  input  logic [1:0] scene_sel,
  output logic       frame_tick,
  output logic [6:0] frame,
  output logic [1:0] scene,
  output logic       mode_a,
  output logic       mode_b,
  output logic       zoom_mode,
  output logic [1:0] fade,
  output logic [1:0] state_o
);

  localparam int SW = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam int RW = (RUN_FRAMES > 1) ? $clog2(RUN_FRAMES) : 1;
  localparam logic [SW-1:0] STEP_LAST  = SW'(FADE_STEP - 1);
  localparam logic [RW-1:0] RUN_LAST   = RW'(RUN_FRAMES - 1);
  localparam logic [1:0]    SCENE_LAST = 2'(NUM_SCENES - 1);

  logic tick;
  logic adv;
  logic skip_now;
  logic step_hit;

  state_e        state_q, state_d;
  logic [1:0]    fade_q, fade_d;
  logic [SW-1:0] step_q, step_d;
  logic [RW-1:0] run_q, run_d;
  logic [6:0]    frame_q, frame_d;
  logic [1:0]    scene_q, scene_d;
  logic [1:0]    scene_nxt;
  logic          skip_pend_q, skip_pend_d;
  mode_t         mode_q;

  frame_tick_gen u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync_i (vsync),
    .tick_o  (tick)
  );

  assign adv      = tick & ~pause;
  // A skip arriving in the tick cycle itself counts for that advance.
  assign skip_now = skip_pend_q | skip;
  assign step_hit = (step_q == STEP_LAST);

  // Out-of-range scene_sel values are loaded unchanged.
  always_comb begin
    scene_nxt = 2'd0;
    if (scene_lock) begin
      scene_nxt = scene_sel;
    end else if (scene_q != SCENE_LAST) begin
      scene_nxt = scene_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FADE_IN;
      fade_q      <= 2'd0;
      step_q      <= '0;
      run_q       <= '0;
      frame_q     <= 7'd0;
      scene_q     <= 2'd0;
      skip_pend_q <= 1'b0;
      mode_q      <= '0;
    end else begin
      state_q     <= state_d;
      fade_q      <= fade_d;
      step_q      <= step_d;
      run_q       <= run_d;
      frame_q     <= frame_d;
      scene_q     <= scene_d;
      skip_pend_q <= skip_pend_d;
      mode_q      <= mode_decode(scene_d);
    end
  end

  always_comb begin
    state_d     = state_q;
    fade_d      = fade_q;
    step_d      = step_q;
    run_d       = run_q;
    frame_d     = frame_q;
    scene_d     = scene_q;
    // Pending skips accumulate across paused ticks; every advance consumes
    // or discards them.
    skip_pend_d = skip_now;

    if (adv) begin
      skip_pend_d = 1'b0;
      frame_d     = frame_q + 7'd1;
      unique case (state_q)
        FADE_IN: begin
          if (skip_now) begin
            state_d = FADE_OUT;
            step_d  = '0;
          end else if (step_hit) begin
            step_d = '0;
            fade_d = fade_q + 2'd1;
            if (fade_q == FADE_MAX - 2'd1) begin
              state_d = RUN;
              run_d   = '0;
            end
          end else begin
            step_d = step_q + SW'(1);
          end
        end
        RUN: begin
          fade_d = FADE_MAX;
          if (skip_now || run_q == RUN_LAST) begin
            state_d = FADE_OUT;
            step_d  = '0;
          end else begin
            run_d = run_q + RW'(1);
          end
        end
        FADE_OUT: begin
          if (step_hit) begin
            step_d = '0;
            // The step taken at fade 0 is the last one of the scene.
            if (fade_q == 2'd0) begin
              scene_d = scene_nxt;
              frame_d = 7'd0;
              fade_d  = 2'd0;
              state_d = FADE_IN;
            end else begin
              fade_d = fade_q - 2'd1;
            end
          end else begin
            step_d = step_q + SW'(1);
          end
        end
        default: begin
          state_d = FADE_IN;
          fade_d  = 2'd0;
          step_d  = '0;
        end
      endcase
    end
  end

  assign frame_tick = tick;
  assign frame      = frame_q;
  assign scene      = scene_q;
  assign fade       = fade_q;
  assign state_o    = state_q;
  assign mode_a     = mode_q.mode_a;
  assign mode_b     = mode_q.mode_b;
  assign zoom_mode  = mode_q.zoom_mode;

endmodule

// File: tb/tb_demo_scene_sequencer.sv
module tb_demo_scene_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b0;
  logic       pause = 1'b0;
  logic       skip = 1'b0;
  logic       scene_lock = 1'b0;
  logic [1:0] scene_sel = 2'd0;
  logic       frame_tick;
  logic [6:0] frame;
  logic [1:0] scene;
  logic       mode_a, mode_b, zoom_mode;
  logic [1:0] fade;
  logic [1:0] state_o;

  demo_scene_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .pause      (pause),
    .skip       (skip),
    .scene_lock (scene_lock),
    .scene_sel  (scene_sel),
    .frame_tick (frame_tick),
    .frame      (frame),
    .scene      (scene),
    .mode_a     (mode_a),
    .mode_b     (mode_b),
    .zoom_mode  (zoom_mode),
    .fade       (fade),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       chk;
    logic [6:0] frame;
    logic [1:0] scene;
    logic [1:0] fade;
    logic [1:0] state;
  } exp_t;

  typedef struct {
    int         n;
    logic       pause;
    int         skip_mode;   // 0 none, 1 pulse before first vsync, 2 pulse in tick cycle
    logic       lock;
    logic [1:0] sel;
    logic [6:0] frame;
    logic [1:0] scene;
    logic [1:0] fade;
    logic [1:0] state;
  } vec_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   tick_count = 0;
  int   pulse_count = 0;
  logic cmp_next = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: the outputs settle on the edge after each tick.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      cmp_next = 1'b0;
    end else begin
      if (cmp_next) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          e = sb_q.pop_front();
          if (e.chk) begin
            chk("frame", frame, e.frame);
            chk("scene", scene, e.scene);
            chk("fade", fade, e.fade);
            chk("state", state_o, e.state);
            chk("mode_a", mode_a, e.scene[1]);
            chk("mode_b", mode_b, e.scene[1] ^ e.scene[0]);
            chk("zoom_mode", zoom_mode, e.scene[1] & e.scene[0]);
          end
        end
      end
      cmp_next = frame_tick;
      if (frame_tick) tick_count++;
    end
  end

  // Called at posedge+1; leaves at posedge+1.
  task automatic vsync_pulse(input exp_t e, input int skip_mode);
    sb_q.push_back(e);
    pulse_count++;
    if (skip_mode == 1) begin
      skip = 1'b1;
      @(posedge clk); #1;
      skip = 1'b0;
    end
    vsync = 1'b1;
    @(posedge clk); #1;
    if (skip_mode == 2) skip = 1'b1;
    @(posedge clk); #1;
    skip = 1'b0;
    @(posedge clk); #1;
    vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Undisturbed scene as a function of advances k (1..123) into the scene.
  function automatic exp_t model(input int k, input logic [1:0] sc);
    exp_t e;
    e.chk   = 1'b1;
    e.frame = 7'(k);
    e.scene = sc;
    if (k < 12) begin
      e.state = 2'd0;
      e.fade  = 2'(k / 4);
    end else if (k < 108) begin
      e.state = 2'd1;
      e.fade  = 2'd3;
    end else begin
      e.state = 2'd2;
      e.fade  = 2'(3 - (k - 108) / 4);
    end
    return e;
  endfunction

  vec_t vecs[21];

  initial begin
    exp_t e;
    int   t0;

    vecs[0]  = '{16, 0, 0, 0, 2'd0, 7'd16, 2'd0, 2'd3, 2'd1};
    vecs[1]  = '{ 6, 0, 0, 0, 2'd0, 7'd22, 2'd0, 2'd3, 2'd1};
    vecs[2]  = '{ 1, 0, 1, 0, 2'd0, 7'd23, 2'd0, 2'd3, 2'd2};
    vecs[3]  = '{ 4, 0, 0, 0, 2'd0, 7'd27, 2'd0, 2'd2, 2'd2};
    vecs[4]  = '{12, 0, 0, 0, 2'd0, 7'd0,  2'd1, 2'd0, 2'd0};
    vecs[5]  = '{ 4, 0, 0, 0, 2'd0, 7'd4,  2'd1, 2'd1, 2'd0};
    vecs[6]  = '{ 1, 0, 1, 0, 2'd0, 7'd5,  2'd1, 2'd1, 2'd2};
    vecs[7]  = '{ 3, 0, 0, 0, 2'd0, 7'd8,  2'd1, 2'd1, 2'd2};
    vecs[8]  = '{ 1, 0, 0, 0, 2'd0, 7'd9,  2'd1, 2'd0, 2'd2};
    vecs[9]  = '{ 3, 0, 0, 0, 2'd0, 7'd12, 2'd1, 2'd0, 2'd2};
    vecs[10] = '{ 1, 0, 0, 0, 2'd0, 7'd0,  2'd2, 2'd0, 2'd0};
    vecs[11] = '{ 5, 0, 0, 0, 2'd0, 7'd5,  2'd2, 2'd1, 2'd0};
    vecs[12] = '{20, 1, 1, 0, 2'd0, 7'd5,  2'd2, 2'd1, 2'd0};
    vecs[13] = '{ 1, 0, 0, 0, 2'd0, 7'd6,  2'd2, 2'd1, 2'd2};
    vecs[14] = '{ 8, 0, 0, 0, 2'd0, 7'd0,  2'd3, 2'd0, 2'd0};
    vecs[15] = '{ 1, 0, 1, 0, 2'd0, 7'd1,  2'd3, 2'd0, 2'd2};
    vecs[16] = '{ 4, 0, 0, 1, 2'd2, 7'd0,  2'd2, 2'd0, 2'd0};
    vecs[17] = '{ 1, 0, 1, 0, 2'd0, 7'd1,  2'd2, 2'd0, 2'd2};
    vecs[18] = '{ 4, 0, 0, 0, 2'd0, 7'd0,  2'd3, 2'd0, 2'd0};
    vecs[19] = '{ 1, 0, 2, 0, 2'd0, 7'd1,  2'd3, 2'd0, 2'd2};
    vecs[20] = '{ 2, 0, 0, 0, 2'd0, 7'd3,  2'd3, 2'd0, 2'd2};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_frame_tick", frame_tick, 0);
    chk("rst_frame", frame, 0);
    chk("rst_scene", scene, 0);
    chk("rst_fade", fade, 0);
    chk("rst_state", state_o, 0);
    chk("rst_modes", {mode_a, mode_b, zoom_mode}, 0);

    // First frame by hand: tick timing relative to vsync.
    @(posedge clk); #1;
    e = '{1'b1, 7'd1, 2'd0, 2'd0, 2'd0};
    sb_q.push_back(e);
    pulse_count++;
    vsync = 1'b1;
    @(negedge clk);
    chk("tick_early", frame_tick, 0);
    @(negedge clk);
    chk("tick_high", frame_tick, 1);
    chk("frame_before_adv", frame, 0);
    @(negedge clk);
    chk("tick_width", frame_tick, 0);
    @(posedge clk); #1;
    vsync = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Four undisturbed scenes, checked every frame; ends back in scene 0.
    for (int n = 2; n <= 496; n++) begin
      int k;
      logic [1:0] sc;
      k  = ((n - 1) % 124) + 1;
      sc = 2'((n - 1) / 124);
      if (k == 124) e = '{1'b1, 7'd0, 2'(sc + 2'd1), 2'd0, 2'd0};
      else          e = model(k, sc);
      vsync_pulse(e, 0);
    end

    // Skip, pause and lock scenarios.
    for (int v = 0; v < 21; v++) begin
      pause      = vecs[v].pause;
      scene_lock = vecs[v].lock;
      scene_sel  = vecs[v].sel;
      t0 = tick_count;
      for (int p = 0; p < vecs[v].n; p++) begin
        e.chk   = (p == vecs[v].n - 1);
        e.frame = vecs[v].frame;
        e.scene = vecs[v].scene;
        e.fade  = vecs[v].fade;
        e.state = vecs[v].state;
        vsync_pulse(e, (p == 0) ? vecs[v].skip_mode : 0);
      end
      if (vecs[v].pause) chk("pause_ticks", tick_count - t0, vecs[v].n);
    end
    pause = 1'b0;
    scene_lock = 1'b0;

    // Asynchronous reset in the middle of FADE_OUT, away from any edge.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("async_frame", frame, 0);
    chk("async_scene", scene, 0);
    chk("async_fade", fade, 0);
    chk("async_state", state_o, 0);
    chk("async_modes", {mode_a, mode_b, zoom_mode}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    vsync_pulse('{1'b1, 7'd1, 2'd0, 2'd0, 2'd0}, 0);

    repeat (5) @(posedge clk);
    chk("sb_empty", sb_q.size(), 0);
    chk("tick_total", tick_count, pulse_count);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
